// File: rtl/matrix_operand_loader_if.sv
// Operand stream input and accelerator-side outputs of the matrix operand loader.
// The master drives the word stream; the slave is the loader itself.
interface matrix_operand_loader_if #(
  parameter int unsigned BIT_LENGTH = 16,
  parameter int unsigned PORT_COUNT = 4
);
  logic [BIT_LENGTH-1:0]            in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic                             abort;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplier_input;
  logic [PORT_COUNT*BIT_LENGTH-1:0] multiplicand_input;
  logic                             mStart;
  logic                             Add;
  logic                             direct;
  logic                             busy;
  logic                             done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, multiplier_input, multiplicand_input, mStart, Add, direct, busy, done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, multiplier_input, multiplicand_input, mStart, Add, direct, busy, done
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Collects PORT_COUNT multiplier words then PORT_COUNT multiplicand words from a valid/ready
// stream, then sequences mStart, Add and a HOLD window for the accelerator.
module matrix_operand_loader #(
  parameter int unsigned BIT_LENGTH  = 16,
  parameter int unsigned PORT_COUNT  = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic                    Clk,
  input logic                    Rst,
  matrix_operand_loader_if.slave bus
);

  localparam int unsigned LaneW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(PORT_COUNT - 1);
  localparam logic [HoldW-1:0] LastHold = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StAdd,
    StHold
  } state_e;

  state_e                           state_q, state_d;
  logic [LaneW-1:0]                 lane_q, lane_d;
  logic [HoldW-1:0]                 hold_q, hold_d;
  logic [PORT_COUNT*BIT_LENGTH-1:0] mplier_q, mplier_d;
  logic [PORT_COUNT*BIT_LENGTH-1:0] mcand_q, mcand_d;
  logic                             in_ready_q, mstart_q, add_q, direct_q, busy_q, done_q;
  logic                             xfer;
  logic                             last_lane;

  // in_ready_q is only ever set for the two LOAD states, so it doubles as the load qualifier.
  assign xfer      = bus.in_valid & in_ready_q & ~bus.abort;
  assign last_lane = (lane_q == LastLane);

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    hold_d   = hold_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;

    if (xfer) begin
      for (int unsigned k = 0; k < PORT_COUNT; k++) begin
        if (lane_q == LaneW'(k)) begin
          if (state_q == StLoadA) mplier_d[k*BIT_LENGTH +: BIT_LENGTH] = bus.in_data;
          else                    mcand_d[k*BIT_LENGTH +: BIT_LENGTH]  = bus.in_data;
        end
      end
    end

    if (bus.abort) begin
      state_d = StLoadA;
      lane_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoadA;
        StLoadA, StLoadB: begin
          if (xfer) begin
            lane_d = last_lane ? '0 : lane_q + 1'b1;
            if (last_lane) state_d = (state_q == StLoadA) ? StLoadB : StStart;
          end
        end
        StStart: state_d = StAdd;
        StAdd: begin
          state_d = StHold;
          hold_d  = '0;
        end
        StHold: begin
          if (hold_q == LastHold) begin
            state_d = StLoadA;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      hold_q     <= '0;
      mplier_q   <= '0;
      mcand_q    <= '0;
      in_ready_q <= 1'b0;
      mstart_q   <= 1'b0;
      add_q      <= 1'b0;
      direct_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      hold_q     <= hold_d;
      mplier_q   <= mplier_d;
      mcand_q    <= mcand_d;
      // Flags are decoded from the next state so each output comes straight from a flop.
      in_ready_q <= (state_d == StLoadA) || (state_d == StLoadB);
      mstart_q   <= (state_d == StStart);
      add_q      <= (state_d == StAdd);
      direct_q   <= (state_d == StStart) || (state_d == StAdd) || (state_d == StHold);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StHold) && (hold_d == LastHold);
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.multiplier_input   = mplier_q;
  assign bus.multiplicand_input = mcand_q;
  assign bus.mStart             = mstart_q;
  assign bus.Add                = add_q;
  assign bus.direct             = direct_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed and random rounds checked against a lane-array
// model of the operands and the fixed START/ADD/HOLD timeline.
module tb_matrix_operand_loader;

  localparam int unsigned BW = 16;
  localparam int unsigned P  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned N  = 2 * P;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  matrix_operand_loader_if #(.BIT_LENGTH(BW), .PORT_COUNT(P)) bus ();

  matrix_operand_loader #(
    .BIT_LENGTH (BW),
    .PORT_COUNT (P),
    .HOLD_CYCLES(H)
  ) dut (
    .Clk(clk),
    .Rst(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] words [N];
  logic [BW-1:0] exp_a [P];
  logic [BW-1:0] exp_b [P];

  function automatic logic [P*BW-1:0] pack(input logic [BW-1:0] l [P]);
    logic [P*BW-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) r[k*BW +: BW] = l[k];
    return r;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [P*BW-1:0] obs, input logic [P*BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_operands(input string tag);
    checkv({tag, "_mplier"}, bus.multiplier_input, pack(exp_a));
    checkv({tag, "_mcand"}, bus.multiplicand_input, pack(exp_b));
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check1({tag, "_mStart"}, bus.mStart, 1'b0);
    check1({tag, "_Add"}, bus.Add, 1'b0);
    check1({tag, "_direct"}, bus.direct, 1'b0);
    check1({tag, "_busy"}, bus.busy, 1'b0);
    check1({tag, "_done"}, bus.done, 1'b0);
    checkv({tag, "_mplier"}, bus.multiplier_input, '0);
    checkv({tag, "_mcand"}, bus.multiplicand_input, '0);
  endtask

  // Present words[idx] after 'gap' idle cycles; transfer idx lands in lane idx mod P.
  task automatic feed(input int idx, input int gap, input bit ab);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = BW'($urandom);
      @(negedge clk);
      check1("gap_in_ready", bus.in_ready, 1'b1);
      check1("gap_mStart", bus.mStart, 1'b0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = words[idx];
    bus.abort    = ab;
    if (!ab) begin
      if (idx < int'(P)) exp_a[idx] = words[idx];
      else               exp_b[idx - int'(P)] = words[idx];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    if (ab || idx != int'(N) - 1) begin
      check1("load_in_ready", bus.in_ready, 1'b1);
      check1("load_mStart", bus.mStart, 1'b0);
      check1("load_direct", bus.direct, 1'b0);
      check1("load_busy", bus.busy, 1'b1);
    end
    check_operands("load");
  endtask

  // Called at the START cycle; walks ADD and the HOLD window back to LOAD_A.
  task automatic finish_round();
    check1("start_mStart", bus.mStart, 1'b1);
    check1("start_Add", bus.Add, 1'b0);
    check1("start_direct", bus.direct, 1'b1);
    check1("start_in_ready", bus.in_ready, 1'b0);
    check1("start_done", bus.done, 1'b0);
    check_operands("start");
    bus.in_valid = 1'($urandom);
    bus.in_data  = BW'($urandom);
    @(negedge clk);
    check1("add_mStart", bus.mStart, 1'b0);
    check1("add_Add", bus.Add, 1'b1);
    check1("add_direct", bus.direct, 1'b1);
    check1("add_in_ready", bus.in_ready, 1'b0);
    for (int h = 0; h < int'(H); h++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = BW'($urandom);
      @(negedge clk);
      check1("hold_direct", bus.direct, 1'b1);
      check1("hold_Add", bus.Add, 1'b0);
      check1("hold_in_ready", bus.in_ready, 1'b0);
      check1("hold_done", bus.done, (h == int'(H) - 1));
      check_operands("hold");
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check1("next_in_ready", bus.in_ready, 1'b1);
    check1("next_direct", bus.direct, 1'b0);
    check1("next_done", bus.done, 1'b0);
    check1("next_busy", bus.busy, 1'b1);
  endtask

  task automatic run_round(input int gap_mode);
    int g;
    for (int i = 0; i < int'(N); i++) begin
      g = (gap_mode < 0) ? int'($urandom_range(3, 0)) : gap_mode;
      feed(i, g, 1'b0);
    end
    finish_round();
  endtask

  task automatic random_words();
    for (int k = 0; k < int'(N); k++) words[k] = BW'($urandom);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.abort    = 1'b0;
    for (int k = 0; k < int'(P); k++) begin
      exp_a[k] = '0;
      exp_b[k] = '0;
    end

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check1("idle_in_ready", bus.in_ready, 1'b0);
    check1("idle_busy", bus.busy, 1'b0);
    @(negedge clk);
    check1("first_in_ready", bus.in_ready, 1'b1);
    check1("first_busy", bus.busy, 1'b1);

    // Back-to-back reference round.
    words = '{16'h4000, 16'h5a05, 16'h5800, 16'h0003, 16'h4000, 16'h5027, 16'h4e68, 16'h0001};
    run_round(0);
    checkv("ref_mplier", bus.multiplier_input, 64'h0003_5800_5a05_4000);
    checkv("ref_mcand", bus.multiplicand_input, 64'h0001_4e68_5027_4000);

    // Same words with three idle cycles before each one.
    run_round(3);
    checkv("gap_mplier", bus.multiplier_input, 64'h0003_5800_5a05_4000);
    checkv("gap_mcand", bus.multiplicand_input, 64'h0001_4e68_5027_4000);

    // Second round replaces every lane.
    words = '{16'h0000, 16'h0010, 16'h0001, 16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    run_round(0);
    checkv("r2_mplier", bus.multiplier_input, 64'h0003_0001_0010_0000);
    checkv("r2_mcand", bus.multiplicand_input, 64'h0001_0001_0001_0001);

    // Abort together with the final multiplicand transfer: that word is dropped.
    random_words();
    for (int i = 0; i < int'(N) - 1; i++) feed(i, 0, 1'b0);
    feed(int'(N) - 1, 0, 1'b1);
    @(negedge clk);
    check1("abort_idle_mStart", bus.mStart, 1'b0);
    check1("abort_idle_in_ready", bus.in_ready, 1'b1);
    random_words();
    run_round(0);

    // Abort in the START cycle.
    random_words();
    for (int i = 0; i < int'(N); i++) feed(i, 0, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check1("abort_start_in_ready", bus.in_ready, 1'b1);
    check1("abort_start_Add", bus.Add, 1'b0);
    check1("abort_start_direct", bus.direct, 1'b0);
    check1("abort_start_done", bus.done, 1'b0);
    check_operands("abort_start");
    random_words();
    run_round(-1);

    // Reset pulse during the first HOLD cycle.
    random_words();
    for (int i = 0; i < int'(N); i++) feed(i, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check1("pre_rst_direct", bus.direct, 1'b1);
    check1("pre_rst_done", bus.done, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < int'(P); k++) begin
      exp_a[k] = '0;
      exp_b[k] = '0;
    end
    check_all_zero("hold_rst");
    repeat (2) begin
      @(negedge clk);
      check1("rst_no_done", bus.done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check1("post_rst_in_ready", bus.in_ready, 1'b1);
    random_words();
    run_round(-1);

    repeat (4) begin
      random_words();
      run_round(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
